lattice_seq: RTL and testbench
==============================

// Module: lattice_seq
// PURPOSE
//  Sequencer for the all-pole lattice synthesis filter; it is the initiator side of the serial/parallel multiplier start/done handshake.
//  Per input sample it walks the filter sections from NSECT-1 down to 0 and issues two multiplies per section (one for the last section).
//  It accumulates with saturation, keeps the backward-path state, and emits one 16-bit output sample.
//  Position: between the excitation source and the DAC path; the 16x10 multiplier is external.
// PARAMETERS
//  NSECT  12  number of lattice sections, legal range 1..16
// PORTS
//  clk          in   1   clock
//  rst_an       in   1   reset, asynchronous, active-low
//  smp_in       in   16  signed excitation sample
//  smp_stb      in   1   one-cycle strobe: smp_in valid
//  clr_state    in   1   request to zero all backward-state registers
//  coef_addr    out  4   section index i; external regfile returns coef_data combinationally
//  coef_data    in   10  k_i, sign-magnitude Q0.9 (bit9 = sign, bits 8:0 = magnitude/512)
//  mul_sig      out  16  signed multiplicand, registered
//  mul_coef     out  10  coefficient to multiplier, registered
//  mul_start    out  1   multiply request, one-cycle pulse
//  mul_result   in   16  signed product (sig*k), valid when mul_done rises
//  mul_done     in   1   multiplier idle/result-valid
//  smp_out      out  16  signed filter output
//  out_valid    out  1   one-cycle pulse: smp_out updated
//  busy         out  1   high from LOAD through DONE
//  overrun      out  1   one-cycle pulse: smp_stb arrived while busy, and that sample was dropped
// BEHAVIOUR
//  Reset values: all outputs 0; b[0..NSECT-1] = 0; f = 0; state = IDLE; i = 0.
//  Recursion: f = x; for i = NSECT-1..0: { f = sat(f - k_i*b[i]); if i < NSECT-1: b[i+1] = sat(b[i] + k_i*f) }; b[0] = f; out = f.
//  sat(): form a 17-bit sum, then clamp to [-32768, 32767].
//  State machine:
//   IDLE   - smp_stb: latch f = smp_in, i = NSECT-1, go to LOAD.
//          - else if clr_state, or a clear is pending: zero all b, drop the pending flag.
//   LOAD   - one cycle; coef_addr = i; go to MUL_F.
//   MUL_F  - mul_sig <= b[i]; mul_coef <= coef_data; mul_start = 1; go to WAIT_F.
//   WAIT_F - mul_done ignored in its first cycle (guard); later, mul_done = 1 captures p, go to UPD_F.
//   UPD_F  - f <= sat(f - p).
//          - if i == NSECT-1: go to NEXT (skip the b[NSECT] product).
//          - else: go to MUL_B.
//   MUL_B  - mul_sig <= f; mul_coef <= coef_data; mul_start = 1; go to WAIT_B (same guard rule).
//   WAIT_B - same as WAIT_F; on capture go to UPD_B.
//   UPD_B  - b[i+1] <= sat(b[i] + p); go to NEXT.
//   NEXT   - if i == 0: go to DONE.
//          - else: i <= i-1, coef_addr follows, go to MUL_F.
//   DONE   - b[0] <= f; smp_out <= f; out_valid = 1; go to IDLE.
//  mul_start is asserted only from MUL_F or MUL_B, never twice per product.
//  mul_sig and mul_coef hold steady until the next MUL_x state.
//  Latency: with a multiplier that returns done 12 cycles after sampling start, each product costs 14 cycles (MUL + 12 WAIT + UPD).
//   Per sample: 2 + 14*(2*NSECT-1) + NSECT cycles from the smp_stb edge to out_valid. For NSECT = 12 this is 336.
//  smp_stb while busy: the sample is dropped, overrun pulses once, and the computation in progress is unaffected.
//  smp_stb and clr_state in the same IDLE cycle: the sample wins; the clear is latched as pending and applied in the first IDLE cycle after DONE.
//  clr_state while busy: latched as pending; it never corrupts the sample in progress.
//  rst_an low mid-operation: immediate return to reset values; no further mul_start; a multiply already in flight is abandoned.
//  mul_done stuck low: the sequencer stays in WAIT indefinitely. There is no timeout.
// STRUCTURE
//  Shared package lattice_pkg:
//   - state encoding localparams;
//   - SAT16 function (17-bit to 16-bit clamp);
//   - widths SMP_W = 16, COEF_W = 10.
//  One sub-module: lattice_state_rf, an NSECT x 16 register file.
//   - one read port indexed by i (b[i]);
//   - one write port for b[i+1] or b[0];
//   - synchronous clear-all.
//  Everything else stays inline in lattice_seq.
// TESTING
//  Bench pairs this block with the team multiplier model (done returns 12 cycles after start).
//  1. Reset: hold rst_an low, then release -> all outputs 0, busy = 0, no mul_start for 50 cycles.
//  2. NSECT=1, k0 = 10'h100 (+0.5); inputs 1000, 0, 0 -> outputs 1000, -500, 250.
//     out_valid spacing equals the formula (17 cycles from strobe).
//  3. NSECT=12, all k = 0, input 1234 -> smp_out = 1234 after 336 cycles; exactly 23 mul_start pulses.
//  4. Saturation: NSECT=1, k0 = 10'h1FF, b0 preloaded to -32768 via a prior sample; input 32767 -> smp_out = 32767 (clamped, no wrap).
//  5. smp_stb pulsed at cycle 5 of a busy period -> overrun = 1 for one cycle.
//     The current sample completes unchanged; the dropped sample never appears.
//  6. clr_state while busy, then next sample 0 with NSECT=1, k0 = 10'h100 -> output 0 (state cleared after DONE).
//     Separately: rst_an pulsed mid-WAIT_F -> busy = 0, and the next sample computes from zero state.

Source files
------------

// File: rtl/lattice_pkg.sv
// Shared types, widths and the saturating clamp for the lattice filter sequencer.
package lattice_pkg;

  localparam int SMP_W  = 16;
  localparam int COEF_W = 10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_MUL_F,
    S_WAIT_F,
    S_UPD_F,
    S_MUL_B,
    S_WAIT_B,
    S_UPD_B,
    S_NEXT,
    S_DONE
  } state_e;

  // Clamp a 17-bit two's-complement sum into the 16-bit sample range.
  // Overflow shows as disagreement between the two top bits.
  function automatic logic signed [SMP_W-1:0] SAT16(input logic signed [SMP_W:0] v);
    if (v[SMP_W] != v[SMP_W-1])
      return v[SMP_W] ? 16'sh8000 : 16'sh7FFF;
    else
      return v[SMP_W-1:0];
  endfunction

endpackage

// File: rtl/lattice_seq_if.sv
// Start/done handshake between the lattice sequencer (master) and the
// external serial/parallel multiplier (slave).
interface lattice_seq_if;
  import lattice_pkg::*;

  logic signed [SMP_W-1:0]  mul_sig;
  logic        [COEF_W-1:0] mul_coef;
  logic                     mul_start;
  logic signed [SMP_W-1:0]  mul_result;
  logic                     mul_done;

  modport master (
    output mul_sig, mul_coef, mul_start,
    input  mul_result, mul_done
  );

  modport slave (
    input  mul_sig, mul_coef, mul_start,
    output mul_result, mul_done
  );

endinterface

// File: rtl/lattice_state_rf.sv
// Backward-path state b[0..NSECT-1]: one async read port, one write port,
// synchronous clear-all.
module lattice_state_rf
  import lattice_pkg::*;
#(
  parameter int NSECT = 12
) (
  input  logic                    clk,
  input  logic                    rst_an,
  input  logic                    clr_i,
  input  logic                    we_i,
  input  logic [3:0]              raddr_i,
  input  logic [3:0]              waddr_i,
  input  logic signed [SMP_W-1:0] wdata_i,
  output logic signed [SMP_W-1:0] rdata_o
);

  localparam int AW = (NSECT > 1) ? $clog2(NSECT) : 1;

  logic signed [SMP_W-1:0] b_q [NSECT];

  assign rdata_o = b_q[raddr_i[AW-1:0]];

  // Storage: reset and clear zero every entry; otherwise one word per write.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      for (int unsigned j = 0; j < NSECT; j++) b_q[j] <= '0;
    end else if (clr_i) begin
      for (int unsigned j = 0; j < NSECT; j++) b_q[j] <= '0;
    end else if (we_i) begin
      b_q[waddr_i[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/lattice_seq.sv
// All-pole lattice synthesis sequencer: walks sections NSECT-1..0 per sample,
// drives the external multiplier, accumulates with saturation.
module lattice_seq
  import lattice_pkg::*;
#(
  parameter int NSECT = 12
) (
  input  logic                     clk,
  input  logic                     rst_an,
  input  logic signed [SMP_W-1:0]  smp_in,
  input  logic                     smp_stb,
  input  logic                     clr_state,
  output logic [3:0]               coef_addr,
  input  logic [COEF_W-1:0]        coef_data,
  lattice_seq_if.master            mul,
  output logic signed [SMP_W-1:0]  smp_out,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam logic [3:0] LAST = 4'(NSECT - 1);

  state_e                  state_q;
  logic [3:0]              i_q;
  logic signed [SMP_W-1:0] f_q;
  logic signed [SMP_W-1:0] p_q;
  logic signed [SMP_W-1:0] mul_sig_q;
  logic [COEF_W-1:0]       mul_coef_q;
  logic                    mul_start_q;
  logic signed [SMP_W-1:0] smp_out_q;
  logic                    out_valid_q;
  logic                    busy_q;
  logic                    overrun_q;
  logic                    clr_pend_q;
  logic                    wait_first_q;

  logic                    rf_clr_d;
  logic                    rf_we_d;
  logic [3:0]              rf_waddr_d;
  logic signed [SMP_W-1:0] rf_wdata_d;
  logic signed [SMP_W-1:0] b_rd;
  logic signed [SMP_W:0]   sum_f;
  logic signed [SMP_W:0]   sum_b;

  assign sum_f = {f_q[SMP_W-1], f_q} - {p_q[SMP_W-1], p_q};
  assign sum_b = {b_rd[SMP_W-1], b_rd} + {p_q[SMP_W-1], p_q};

  lattice_state_rf #(.NSECT(NSECT)) u_rf (
    .clk     (clk),
    .rst_an  (rst_an),
    .clr_i   (rf_clr_d),
    .we_i    (rf_we_d),
    .raddr_i (i_q),
    .waddr_i (rf_waddr_d),
    .wdata_i (rf_wdata_d),
    .rdata_o (b_rd)
  );

  // State-file writes happen in the state that produces the value, so b[0]
  // lands in DONE before any pending clear can run in the following IDLE.
  always_comb begin
    rf_clr_d   = (state_q == S_IDLE) && !smp_stb && (clr_state || clr_pend_q);
    rf_we_d    = 1'b0;
    rf_waddr_d = '0;
    rf_wdata_d = f_q;
    if (state_q == S_UPD_B) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = i_q + 1'b1;
      rf_wdata_d = SAT16(sum_b);
    end else if (state_q == S_DONE) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = '0;
      rf_wdata_d = f_q;
    end
  end

  // Sequencer FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      state_q      <= S_IDLE;
      i_q          <= '0;
      f_q          <= '0;
      p_q          <= '0;
      mul_sig_q    <= '0;
      mul_coef_q   <= '0;
      mul_start_q  <= 1'b0;
      smp_out_q    <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      clr_pend_q   <= 1'b0;
      wait_first_q <= 1'b0;
    end else begin
      mul_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      overrun_q   <= busy_q && smp_stb;
      if (busy_q && clr_state) clr_pend_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (smp_stb) begin
            f_q     <= smp_in;
            i_q     <= LAST;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
            if (clr_state) clr_pend_q <= 1'b1;
          end else if (clr_state || clr_pend_q) begin
            clr_pend_q <= 1'b0;
          end
        end
        S_LOAD: state_q <= S_MUL_F;
        S_MUL_F: begin
          mul_sig_q    <= b_rd;
          mul_coef_q   <= coef_data;
          mul_start_q  <= 1'b1;
          wait_first_q <= 1'b1;
          state_q      <= S_WAIT_F;
        end
        S_WAIT_F, S_WAIT_B: begin
          // done is still high from the previous product in the first cycle
          wait_first_q <= 1'b0;
          if (!wait_first_q && mul.mul_done) begin
            p_q     <= mul.mul_result;
            state_q <= (state_q == S_WAIT_F) ? S_UPD_F : S_UPD_B;
          end
        end
        S_UPD_F: begin
          f_q     <= SAT16(sum_f);
          state_q <= (i_q == LAST) ? S_NEXT : S_MUL_B;
        end
        S_MUL_B: begin
          mul_sig_q    <= f_q;
          mul_coef_q   <= coef_data;
          mul_start_q  <= 1'b1;
          wait_first_q <= 1'b1;
          state_q      <= S_WAIT_B;
        end
        S_UPD_B: state_q <= S_NEXT;
        S_NEXT: begin
          if (i_q == '0) begin
            state_q <= S_DONE;
          end else begin
            i_q     <= i_q - 1'b1;
            state_q <= S_MUL_F;
          end
        end
        S_DONE: begin
          smp_out_q   <= f_q;
          out_valid_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign coef_addr     = i_q;
  assign mul.mul_sig   = mul_sig_q;
  assign mul.mul_coef  = mul_coef_q;
  assign mul.mul_start = mul_start_q;
  assign smp_out       = smp_out_q;
  assign out_valid     = out_valid_q;
  assign busy          = busy_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_lattice_seq.sv
// Bench for lattice_seq: one instance with NSECT=1 (index 0), one with
// NSECT=12 (index 1), each paired with a multiplier model and coefficient
// table; outputs are compared against an arithmetic model of the recursion.
module tb_lattice_seq;
  import lattice_pkg::*;

  localparam int NS0     = 1;
  localparam int NS1     = 12;
  localparam int MUL_LAT = 10;   // done is back during the 12th cycle after mul_start rises
  localparam int TMO     = 2000;

  logic clk    = 1'b0;
  logic rst_an = 1'b0;
  always #5 clk = ~clk;

  logic signed [15:0] in0, in1, out0, out1;
  logic               stb0, stb1, clr0, clr1;
  logic [3:0]         ca0, ca1;
  logic [9:0]         cd0, cd1;
  logic               vld0, vld1, busy0, busy1, ovr0, ovr1, st0, st1;
  logic [9:0]         kc0 [16];
  logic [9:0]         kc1 [16];
  logic signed [15:0] mr0, mr1;
  int                 mc0, mc1;

  int n_vec = 0;
  int n_err = 0;
  int bm [2][16];

  lattice_seq_if mif0 ();
  lattice_seq_if mif1 ();

  assign cd0 = kc0[ca0];
  assign cd1 = kc1[ca1];
  assign st0 = mif0.mul_start;
  assign st1 = mif1.mul_start;

  lattice_seq #(.NSECT(NS0)) dut0 (
    .clk(clk), .rst_an(rst_an), .smp_in(in0), .smp_stb(stb0), .clr_state(clr0),
    .coef_addr(ca0), .coef_data(cd0), .mul(mif0), .smp_out(out0),
    .out_valid(vld0), .busy(busy0), .overrun(ovr0)
  );

  lattice_seq #(.NSECT(NS1)) dut1 (
    .clk(clk), .rst_an(rst_an), .smp_in(in1), .smp_stb(stb1), .clr_state(clr1),
    .coef_addr(ca1), .coef_data(cd1), .mul(mif1), .smp_out(out1),
    .out_valid(vld1), .busy(busy1), .overrun(ovr1)
  );

  // sig * k with k sign-magnitude Q0.9, floor of the magnitude product
  function automatic int mulk(input int sig, input logic [9:0] k);
    int p;
    p = (sig * int'(k[8:0])) >>> 9;
    return k[9] ? -p : p;
  endfunction

  function automatic int clamp(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Multiplier models: sample on start, drop done, return result later.
  always @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      mc0 <= 0; mif0.mul_done <= 1'b1; mif0.mul_result <= '0; mr0 <= '0;
    end else if (mc0 == 0) begin
      if (mif0.mul_start) begin
        mc0 <= MUL_LAT; mif0.mul_done <= 1'b0;
        mr0 <= 16'(mulk(int'(mif0.mul_sig), mif0.mul_coef));
      end
    end else begin
      mc0 <= mc0 - 1;
      if (mc0 == 1) begin mif0.mul_done <= 1'b1; mif0.mul_result <= mr0; end
    end
  end

  always @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      mc1 <= 0; mif1.mul_done <= 1'b1; mif1.mul_result <= '0; mr1 <= '0;
    end else if (mc1 == 0) begin
      if (mif1.mul_start) begin
        mc1 <= MUL_LAT; mif1.mul_done <= 1'b0;
        mr1 <= 16'(mulk(int'(mif1.mul_sig), mif1.mul_coef));
      end
    end else begin
      mc1 <= mc1 - 1;
      if (mc1 == 1) begin mif1.mul_done <= 1'b1; mif1.mul_result <= mr1; end
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int nsect(input int d);
    return (d != 0) ? NS1 : NS0;
  endfunction

  function automatic logic [9:0] kk(input int d, input int i);
    return (d != 0) ? kc1[i] : kc0[i];
  endfunction

  function automatic int o_out(input int d);
    return (d != 0) ? int'(out1) : int'(out0);
  endfunction

  function automatic logic o_vld(input int d);   return (d != 0) ? vld1 : vld0;   endfunction
  function automatic logic o_busy(input int d);  return (d != 0) ? busy1 : busy0; endfunction
  function automatic logic o_ovr(input int d);   return (d != 0) ? ovr1 : ovr0;   endfunction
  function automatic logic o_start(input int d); return (d != 0) ? st1 : st0;     endfunction

  task automatic clear_model(input int d);
    for (int i = 0; i < 16; i++) bm[d][i] = 0;
  endtask

  // Reference recursion straight from the filter definition.
  task automatic model_step(input int d, input int x, output int y);
    int n, f;
    n = nsect(d);
    f = x;
    for (int i = n - 1; i >= 0; i--) begin
      f = clamp(f - mulk(bm[d][i], kk(d, i)));
      if (i < n - 1) bm[d][i+1] = clamp(bm[d][i] + mulk(f, kk(d, i)));
    end
    bm[d][0] = f;
    y = f;
  endtask

  task automatic drive(input int d, input int x, input logic stb, input logic clr);
    if (d == 0) begin in0 = 16'(x); stb0 = stb; clr0 = clr; end
    else        begin in1 = 16'(x); stb1 = stb; clr1 = clr; end
  endtask

  // One sample: optional clear in the strobe cycle, a clear pulse at clr_at,
  // and a dropped strobe at inj_at (cycles counted from the accepting edge).
  task automatic run_sample(input int d, input int x, input bit clr_same,
                            input int clr_at, input int inj_at, input int inj_x,
                            output int got);
    int n, lat, nst, novr, exp;
    n = nsect(d);
    model_step(d, x, exp);
    drive(d, x, 1'b1, clr_same);
    @(posedge clk); #1;
    drive(d, x, 1'b0, 1'b0);
    lat = 0; nst = 0; novr = 0;
    while (!o_vld(d) && lat < TMO) begin
      @(posedge clk); #1;
      lat++;
      if (o_start(d)) nst++;
      if (o_ovr(d)) novr++;
      if (lat == inj_at) drive(d, inj_x, 1'b1, lat == clr_at);
      else               drive(d, x, 1'b0, lat == clr_at);
    end
    drive(d, x, 1'b0, 1'b0);
    got = o_out(d);
    chk($sformatf("out_d%0d", d), got, exp);
    chk($sformatf("lat_d%0d", d), lat, 2 + 14 * (2 * n - 1) + n);
    chk($sformatf("nstart_d%0d", d), nst, 2 * n - 1);
    chk($sformatf("overrun_d%0d", d), novr, (inj_at > 0) ? 1 : 0);
    if (clr_same || clr_at > 0) clear_model(d);
    repeat (2) @(posedge clk); #1;
    chk($sformatf("idle_d%0d", d), o_busy(d), 0);
  endtask

  task automatic idle_clear(input int d);
    drive(d, 0, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(d, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    clear_model(d);
  endtask

  task automatic rand_k(input int d);
    for (int i = 0; i < 16; i++) begin
      if (d == 0) kc0[i] = 10'($urandom_range(0, 1023));
      else        kc1[i] = 10'($urandom_range(0, 1023));
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, act, x, d, n1;
    logic signed [15:0] r16;

    drive(0, 0, 1'b0, 1'b0);
    drive(1, 0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin kc0[i] = '0; kc1[i] = '0; end
    clear_model(0);
    clear_model(1);

    // Reset state and quiet period after release
    repeat (4) @(posedge clk); #1;
    chk("rst_out0", int'(out0), 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_vld1", vld1, 0);
    chk("rst_caddr1", ca1, 0);
    chk("rst_start1", st1, 0);
    chk("rst_sig1", int'(mif1.mul_sig), 0);
    rst_an = 1'b1;
    act = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (st0 | st1 | vld0 | vld1 | busy0 | busy1 | ovr0 | ovr1 | (out0 != 0) | (out1 != 0)) act++;
    end
    chk("rst_quiet", act, 0);

    // NSECT=1, k0=+0.5: impulse response 1000, -500, 250
    kc0[0] = 10'h100;
    run_sample(0, 1000, 1'b0, 0, 0, 0, got); chk("t2_s0", got, 1000);
    run_sample(0, 0,    1'b0, 0, 0, 0, got); chk("t2_s1", got, -500);
    run_sample(0, 0,    1'b0, 0, 0, 0, got); chk("t2_s2", got, 250);

    // NSECT=12, all k=0: pass-through, 336 cycles, 23 products
    run_sample(1, 1234, 1'b0, 0, 0, 0, got); chk("t3_out", got, 1234);

    // Saturation: b0 driven to -32768, then a full-scale positive input
    kc0[0] = 10'h1FF;
    run_sample(0, -32768, 1'b0, 0, 0, 0, got); chk("t4_neg", got, -32768);
    run_sample(0, 32767,  1'b0, 0, 0, 0, got); chk("t4_sat", got, 32767);

    // Strobe while busy: dropped, one overrun pulse
    rand_k(1);
    run_sample(1, 3000, 1'b0, 0, 5, -7777, got);
    run_sample(1, -1500, 1'b0, 0, 0, 0, got);

    // Clear while busy takes effect after DONE
    kc0[0] = 10'h100;
    run_sample(0, 777, 1'b0, 3, 0, 0, got);
    run_sample(0, 0,   1'b0, 0, 0, 0, got); chk("t6_clr", got, 0);

    // Reset pulsed while waiting on the first product
    rand_k(1);
    drive(1, 4321, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(1, 4321, 1'b0, 1'b0);
    repeat (5) @(posedge clk); #1;
    chk("mid_busy_pre", busy1, 1);
    rst_an = 1'b0; #1;
    chk("mid_busy", busy1, 0);
    chk("mid_start", st1, 0);
    act = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (st1 | busy1 | vld1) act++;
    end
    chk("mid_quiet", act, 0);
    rst_an = 1'b1;
    clear_model(0);
    clear_model(1);
    @(posedge clk); #1;
    run_sample(1, 9000, 1'b0, 0, 0, 0, got);

    // Randomized samples, coefficients and clears
    n1 = 0;
    for (int it = 0; it < 40; it++) begin
      d = ($urandom_range(0, 7) == 0 && n1 < 4) ? 1 : 0;
      if (d == 1) n1++;
      if ($urandom_range(0, 2) == 0) rand_k(d);
      if ($urandom_range(0, 9) == 0) idle_clear(d);
      r16 = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       x = 32767;
        1:       x = -32768;
        default: x = int'(r16);
      endcase
      run_sample(d, x, $urandom_range(0, 5) == 0,
                 ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 10)) : 0,
                 0, 0, got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
